// File: rtl/uart_pkg.sv
// UART shared definitions, used by the TX engine and by the RX engine.
//   baud_period : baud select code -> system clock cycles per bit (100 MHz clock)
//   frame_len   : {eight, pen} -> number of bits on the line (start..stop)
//   tx_state_t  : transmitter states
//   IDLE_LINE   : mark level of an idle serial line
package uart_pkg;

   localparam int BAUD_CNT_W_DEF = 19;
   localparam int BIT_CNT_W_DEF  = 4;

   localparam logic IDLE_LINE = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } tx_state_t;

   // Codes C..F fall back to the fastest rate so that a zero period can never occur.
   function automatic logic [BAUD_CNT_W_DEF-1:0] baud_period(input logic [3:0] code);
      logic [BAUD_CNT_W_DEF-1:0] p;
      case (code)
         4'h0:    p = 19'd333333;
         4'h1:    p = 19'd83333;
         4'h2:    p = 19'd41667;
         4'h3:    p = 19'd20833;
         4'h4:    p = 19'd10417;
         4'h5:    p = 19'd5208;
         4'h6:    p = 19'd2604;
         4'h7:    p = 19'd1736;
         4'h8:    p = 19'd868;
         4'h9:    p = 19'd434;
         4'hA:    p = 19'd217;
         default: p = 19'd109;
      endcase
      return p;
   endfunction

   function automatic logic [BIT_CNT_W_DEF-1:0] frame_len(input logic eight, input logic pen);
      logic [BIT_CNT_W_DEF-1:0] n;
      case ({eight, pen})
         2'b00:   n = 4'd9;
         2'b11:   n = 4'd11;
         default: n = 4'd10;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit timing for the UART transmitter.
//   clk, rst_n : system clock, async active-low reset
//   clr        : restart both counters (frame accepted)
//   run        : frame in progress
//   period     : cycles per bit (P, never zero)
//   nbits      : bits in the frame (N)
//   btu        : last cycle of the current bit
//   done       : last cycle of the last (stop) bit
module uart_tx_bit_timer #(
   parameter int BAUD_CNT_W = 19,
   parameter int BIT_CNT_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  run,
   input  logic [BAUD_CNT_W-1:0] period,
   input  logic [BIT_CNT_W-1:0]  nbits,
   output logic                  btu,
   output logic                  done
);

   logic [BAUD_CNT_W-1:0] bit_time;
   logic [BIT_CNT_W-1:0]  bit_cnt;

   assign btu  = run && (bit_time == (period - BAUD_CNT_W'(1)));
   assign done = btu && (bit_cnt == (nbits - BIT_CNT_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_time <= '0;
         bit_cnt  <= '0;
      end else if (clr) begin
         bit_time <= '0;
         bit_cnt  <= '0;
      end else if (btu) begin
         bit_time <= '0;
         bit_cnt  <= done ? '0 : bit_cnt + BIT_CNT_W'(1);
      end else if (run) begin
         bit_time <= bit_time + BAUD_CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: one byte per load strobe, sent as start, 7/8 data bits LSB
// first, optional parity and one stop bit.
//   clk, rst_n : system clock (100 MHz), async active-low reset
//   load       : one-cycle strobe, accepted only while txrdy=1
//   out_port   : byte to send (bit 7 dropped for 7-bit frames)
//   eight      : 1 = 8 data bits, 0 = 7
//   pen        : 1 = parity bit appended
//   ohel       : parity sense, 1 = odd, 0 = even
//   baud       : baud select code
//   tx         : serial line, idles high
//   txrdy      : 1 = idle, load will be accepted
//
// state | meaning
// IDLE  | line at mark, txrdy=1, waiting for load
// SEND  | shifting the frame out, one bit per baud period
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int BAUD_CNT_W = BAUD_CNT_W_DEF,
   parameter int BIT_CNT_W  = BIT_CNT_W_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] out_port,
   input  logic       eight,
   input  logic       pen,
   input  logic       ohel,
   input  logic [3:0] baud,
   output logic       tx,
   output logic       txrdy
);

   tx_state_t             state, state_nxt;
   logic                  accept;
   logic                  btu, done;
   logic                  parity;
   logic [10:0]           frame;
   logic [10:0]           shift_q;
   logic [BAUD_CNT_W-1:0] period_q;
   logic [BIT_CNT_W-1:0]  nbits_q;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               accept    = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (done) state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Frame vector is sent bit 0 first; bits above the stop bit stay at mark.
   always_comb begin
      parity = eight ? ^out_port : ^out_port[6:0];
      if (ohel) parity = ~parity;
      frame    = '1;
      frame[0] = 1'b0;
      if (eight) begin
         frame[8:1] = out_port;
         if (pen) frame[9] = parity;
      end else begin
         frame[7:1] = out_port[6:0];
         if (pen) frame[8] = parity;
      end
   end

   // tx is taken straight from the shift register flop, so it is registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q  <= '1;
         txrdy    <= 1'b1;
         period_q <= '0;
         nbits_q  <= '0;
      end else if (accept) begin
         shift_q  <= frame;
         txrdy    <= 1'b0;
         period_q <= BAUD_CNT_W'(baud_period(baud));
         nbits_q  <= BIT_CNT_W'(frame_len(eight, pen));
      end else if (done) begin
         shift_q  <= '1;
         txrdy    <= 1'b1;
      end else if (btu) begin
         shift_q  <= {IDLE_LINE, shift_q[10:1]};
      end
   end

   assign tx = shift_q[0];

   uart_tx_bit_timer #(
      .BAUD_CNT_W (BAUD_CNT_W),
      .BIT_CNT_W  (BIT_CNT_W)
   ) u_bit_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (accept),
      .run    (state == SEND),
      .period (period_q),
      .nbits  (nbits_q),
      .btu    (btu),
      .done   (done)
   );

endmodule

// File: tb/tb_uart_tx_engine.sv
`timescale 1ns/1ps
module tb_uart_tx_engine;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load = 1'b0;
   logic [7:0] out_port = 8'h00;
   logic       eight = 1'b0;
   logic       pen = 1'b0;
   logic       ohel = 1'b0;
   logic [3:0] baud = 4'h0;
   logic       tx;
   logic       txrdy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_tx_engine dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .out_port (out_port),
      .eight    (eight),
      .pen      (pen),
      .ohel     (ohel),
      .baud     (baud),
      .tx       (tx),
      .txrdy    (txrdy)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int per_tab [16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736,
                        868, 434, 217, 109, 109, 109, 109, 109};

   bit          m_busy = 1'b0;
   int          m_el = 0;
   int          m_n = 9;
   int          m_p = 109;
   logic [10:0] m_frame = '1;

   function automatic logic [10:0] build_frame(input logic [7:0] d, input logic e,
                                               input logic p, input logic o);
      logic [10:0] f;
      int nd, ones;
      f    = '1;
      f[0] = 1'b0;
      nd   = e ? 8 : 7;
      ones = 0;
      for (int i = 0; i < nd; i++) begin
         f[1+i] = d[i];
         ones  += int'(d[i]);
      end
      if (p) f[1+nd] = ((ones % 2) == 1) ^ o;
      return f;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0;
         m_el   = 0;
      end else if (!m_busy) begin
         if (load) begin
            m_busy  = 1'b1;
            m_el    = 0;
            m_frame = build_frame(out_port, eight, pen, ohel);
            m_n     = 9 + int'(eight) + int'(pen);
            m_p     = per_tab[baud];
         end
      end else begin
         m_el++;
         if (m_el == m_n * m_p) m_busy = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("tx", int'(tx), m_busy ? int'(m_frame[m_el / m_p]) : 1);
         check("txrdy", int'(txrdy), m_busy ? 0 : 1);
      end
   end

   // ---------------- stimulus ----------------
   task automatic start(input logic [7:0] d, input logic e, input logic p,
                        input logic o, input logic [3:0] b);
      @(posedge clk);
      #1;
      out_port = d; eight = e; pen = p; ohel = o; baud = b;
      load = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   // Called just after the accepting edge; counts busy cycles and start-bit length.
   task automatic measure(output int dur, output int low);
      bit seen_one = 1'b0;
      dur = 0;
      low = 0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (txrdy) break;
         dur++;
         if (!seen_one && tx == 1'b0) low++;
         else seen_one = 1'b1;
      end
   endtask

   initial begin
      #1000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dur, low, exp_dur;
      logic [7:0] d;
      logic e, p, o;
      logic [3:0] b;

      repeat (3) @(posedge clk);
      #1;
      check("reset_tx", int'(tx), 1);
      check("reset_txrdy", int'(txrdy), 1);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // 1: 8E parity even, A5
      start(8'hA5, 1'b1, 1'b1, 1'b0, 4'hB);
      check("frame1", int'(m_frame), int'(11'b10101001010));
      measure(dur, low);
      check("dur1", dur, 1199);
      check("start_len1", low, 109);

      // 2: 7 bits odd parity, C1
      start(8'hC1, 1'b0, 1'b1, 1'b1, 4'hB);
      check("frame2", int'(m_frame), int'(11'b11110000010));
      measure(dur, low);
      check("dur2", dur, 1090);

      // 3: 7N then 8N
      start(8'h55, 1'b0, 1'b0, 1'b0, 4'hB);
      check("frame3a", int'(m_frame), int'(11'b11110101010));
      measure(dur, low);
      check("dur3a", dur, 981);
      start(8'hFF, 1'b1, 1'b0, 1'b0, 4'hB);
      check("frame3b", int'(m_frame), int'(11'b11111111110));
      measure(dur, low);
      check("dur3b", dur, 1090);

      // 4: loads mid-frame and on final btu are ignored; next cycle accepted
      start(8'h5A, 1'b1, 1'b1, 1'b0, 4'hB);
      repeat (500) @(posedge clk);
      #1;
      load = 1'b1; out_port = 8'h00;
      @(posedge clk);
      #1;
      load = 1'b0;
      repeat (1198 - 501) @(posedge clk);
      #1;
      load = 1'b1; out_port = 8'h00; eight = 1'b0;
      @(posedge clk);
      #1;
      out_port = 8'h3C; eight = 1'b1; pen = 1'b0;
      @(negedge clk);
      check("gap_tx", int'(tx), 1);
      check("gap_txrdy", int'(txrdy), 1);
      @(posedge clk);
      #1;
      load = 1'b0;
      @(negedge clk);
      check("reload_tx", int'(tx), 0);
      check("reload_txrdy", int'(txrdy), 0);
      check("frame4", int'(m_frame), int'(11'b11001111000));
      measure(dur, low);
      check("dur4", dur, 1090 - 1);

      // 5: config changes mid-frame have no effect; code F behaves as B
      start(8'hA5, 1'b1, 1'b1, 1'b0, 4'hF);
      fork
         measure(dur, low);
         begin
            repeat (200) @(posedge clk);
            #1;
            baud = 4'h0; ohel = 1'b1; out_port = 8'h00; eight = 1'b0; pen = 1'b0;
            repeat (300) @(posedge clk);
            #1;
            baud = 4'h3; out_port = 8'hFF;
         end
      join
      check("dur5", dur, 1199);
      check("start_len5", low, 109);

      // 6: reset in the 4th bit aborts the frame
      start(8'h96, 1'b1, 1'b1, 1'b1, 4'hB);
      repeat (3 * 109 + 40) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_tx", int'(tx), 1);
      check("abort_txrdy", int'(txrdy), 1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      start(8'h3C, 1'b1, 1'b1, 1'b0, 4'hB);
      measure(dur, low);
      check("dur6", dur, 1199);

      // randomized frames with mid-frame noise
      for (int k = 0; k < 15; k++) begin
         d = 8'($urandom);
         e = 1'($urandom);
         p = 1'($urandom);
         o = 1'($urandom);
         b = 4'($urandom_range(10, 15));
         exp_dur = (9 + int'(e) + int'(p)) * per_tab[b];
         start(d, e, p, o, b);
         fork
            measure(dur, low);
            begin
               repeat ($urandom_range(5, 300)) @(posedge clk);
               #1;
               load = 1'b1;
               out_port = 8'($urandom);
               baud = 4'($urandom_range(0, 15));
               ohel = 1'($urandom);
               eight = 1'($urandom);
               pen = 1'($urandom);
               @(posedge clk);
               #1;
               load = 1'b0;
            end
         join
         check("dur_rand", dur, exp_dur);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
